// File: rtl/trace_capture_if.sv
// Bundle for the trace_capture block: capture controls, commit stream, watched
// channels, readout handshake and status.
interface trace_capture_if #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 16
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic                     Enable;
   logic                     Mode;
   logic                     TrigEn;
   logic [DATA_W-1:0]        TrigPC;
   logic [DATA_W-1:0]        PC_In;
   logic [DATA_W-1:0]        WriteData_In;
   logic                     RegWrite_In;
   logic [NUM_CH*DATA_W-1:0] Ch_In;
   logic                     Rd_Valid;
   logic                     Rd_Ready;
   logic [DATA_W-1:0]        Rd_PC;
   logic [DATA_W-1:0]        Rd_Data;
   logic [3:0]               Rd_Tag;
   logic [CW-1:0]            Count;
   logic                     Full;
   logic                     Overflow;
   logic [15:0]              Dropped;
   logic [1:0]               State;

   modport master (
      output Enable, Mode, TrigEn, TrigPC, PC_In, WriteData_In, RegWrite_In, Ch_In, Rd_Ready,
      input  Rd_Valid, Rd_PC, Rd_Data, Rd_Tag, Count, Full, Overflow, Dropped, State
   );

   modport slave (
      input  Enable, Mode, TrigEn, TrigPC, PC_In, WriteData_In, RegWrite_In, Ch_In, Rd_Ready,
      output Rd_Valid, Rd_PC, Rd_Data, Rd_Tag, Count, Full, Overflow, Dropped, State
   );
endinterface

// File: rtl/trace_capture.sv
// Processor trace capture: records writeback commits and watched-register changes
// into a circular buffer with stop-when-full or wrap-and-overwrite policies.
module trace_capture #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 16
) (
   input logic           Clk,
   input logic           Reset,
   trace_capture_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 2 * DATA_W + 4;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_STOPPED = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [DATA_W-1:0] r_shadow [NUM_CH];
   logic [EW-1:0]     r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [PW-1:0]     w_wr_ptr_nxt;
   logic [PW-1:0]     w_rd_ptr_nxt;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     w_count_nxt;
   logic              r_full;
   logic              r_overflow;
   logic              r_rd_valid;
   logic [15:0]       r_dropped;
   logic [DATA_W-1:0] r_rd_pc;
   logic [DATA_W-1:0] r_rd_data;
   logic [3:0]        r_rd_tag;

   logic [NUM_CH-1:0] w_diff;
   logic [DATA_W+3:0] w_pick;
   logic [EW-1:0]     w_entry;
   logic [EW-1:0]     w_head_nxt;
   logic              w_event;
   logic              w_multi;
   logic              w_trig_hit;
   logic              w_cap_active;
   logic              w_pop;
   logic              w_push;
   logic              w_overwrite;
   logic              w_lost;
   logic              w_drop_window;
   logic              w_stop;

   // Lowest-numbered changed channel as {tag, data}; zero when nothing changed.
   function automatic logic [DATA_W+3:0] pick_channel(
      input logic [NUM_CH*DATA_W-1:0] ch,
      input logic [NUM_CH-1:0]        d
   );
      logic [DATA_W+3:0] sel;
      sel = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (d[k]) sel = {4'(k + 1), ch[k*DATA_W +: DATA_W]};
      end
      return sel;
   endfunction

   // Per-channel change detection against last cycle's shadow copy.
   always_comb begin
      w_diff = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_diff[k] = (bus.Ch_In[k*DATA_W +: DATA_W] != r_shadow[k]);
      end
   end

   // Event selection and push/pop qualification.
   always_comb begin
      w_pick     = pick_channel(bus.Ch_In, w_diff);
      w_event    = bus.RegWrite_In | (|w_diff);
      w_trig_hit = bus.Enable && (bus.PC_In == bus.TrigPC);
      if (bus.RegWrite_In) begin
         w_entry = {bus.PC_In, bus.WriteData_In, 4'd0};
         w_multi = |w_diff;
      end else begin
         w_entry = {bus.PC_In, w_pick[DATA_W-1:0], w_pick[DATA_W+3:DATA_W]};
         w_multi = |(w_diff & (w_diff - NUM_CH'(1)));
      end
      w_cap_active  = (r_state == S_CAPTURE) || ((r_state == S_ARMED) && w_trig_hit);
      w_pop         = r_rd_valid && bus.Rd_Ready;
      w_push        = w_cap_active && w_event && (!r_full || w_pop || bus.Mode);
      w_overwrite   = w_push && r_full && !w_pop;
      w_lost        = w_multi || (w_event && !w_push);
      w_drop_window = (r_state == S_CAPTURE) || (r_state == S_STOPPED);
   end

   // Next pointers, occupancy and the entry that becomes the head.
   always_comb begin
      if (w_push) begin
         w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      end else begin
         w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop || w_overwrite) begin
         w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      end else begin
         w_rd_ptr_nxt = r_rd_ptr;
      end
      if (w_push && !w_pop && !w_overwrite) begin
         w_count_nxt = r_count + CW'(1);
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - CW'(1);
      end else begin
         w_count_nxt = r_count;
      end
      // A push landing in the slot that becomes the head bypasses the memory.
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
         w_head_nxt = w_entry;
      end else begin
         w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
      w_stop = w_push && !bus.Mode && (w_count_nxt == LP_DEPTH);
   end

   // Capture state machine; dropping Enable always returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      if (!bus.Enable) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.TrigEn) begin
                  w_state_nxt = S_ARMED;
               end else begin
                  w_state_nxt = S_CAPTURE;
               end
            end
            S_ARMED: begin
               if (w_trig_hit) begin
                  w_state_nxt = w_stop ? S_STOPPED : S_CAPTURE;
               end else begin
                  w_state_nxt = S_ARMED;
               end
            end
            S_CAPTURE: begin
               w_state_nxt = w_stop ? S_STOPPED : S_CAPTURE;
            end
            S_STOPPED: begin
               w_state_nxt = S_STOPPED;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Trace buffer storage.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   // Shadow copies of the watched channels, refreshed every cycle.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int k = 0; k < NUM_CH; k++) r_shadow[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) r_shadow[k] <= bus.Ch_In[k*DATA_W +: DATA_W];
      end
   end

   // Control state, pointers, status and registered head outputs.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_overflow <= 1'b0;
         r_dropped  <= 16'd0;
         r_rd_pc    <= '0;
         r_rd_data  <= '0;
         r_rd_tag   <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == LP_DEPTH);
         r_rd_valid <= (w_count_nxt != '0);
         r_rd_pc    <= w_head_nxt[EW-1 -: DATA_W];
         r_rd_data  <= w_head_nxt[DATA_W+3:4];
         r_rd_tag   <= w_head_nxt[3:0];
         if (w_overwrite) begin
            r_overflow <= 1'b1;
         end
         if (w_drop_window && w_lost && (r_dropped != 16'hFFFF)) begin
            r_dropped <= r_dropped + 16'd1;
         end
      end
   end

   assign bus.Rd_Valid = r_rd_valid;
   assign bus.Rd_PC    = r_rd_pc;
   assign bus.Rd_Data  = r_rd_data;
   assign bus.Rd_Tag   = r_rd_tag;
   assign bus.Count    = r_count;
   assign bus.Full     = r_full;
   assign bus.Overflow = r_overflow;
   assign bus.Dropped  = r_dropped;
   assign bus.State    = r_state;
endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: vector table for event selection plus
// directed fill, wrap, trigger and reset sequences, with a readout scoreboard.
module tb_trace_capture;
   localparam int DATA_W = 32;
   localparam int NUM_CH = 4;
   localparam int DEPTH  = 16;

   typedef struct {
      logic             rw;
      logic [31:0]      pc;
      logic [31:0]      wd;
      logic [3:0][31:0] ch;
      logic             st;
      logic [31:0]      exp_data;
      logic [3:0]       exp_tag;
      logic [15:0]      exp_drop;
   } vec_t;

   logic Clk;
   logic Reset;
   int   n_checks;
   int   n_fail;
   logic [67:0] sb_q[$];
   vec_t tbl [8];

   trace_capture_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) bus ();

   trace_capture #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every pop seen by the DUT must match the oldest expected entry.
   always @(negedge Clk) begin
      if (Reset && bus.Rd_Valid && bus.Rd_Ready) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got %0h expected no entry", {bus.Rd_PC, bus.Rd_Data, bus.Rd_Tag});
         end else begin
            if ({bus.Rd_PC, bus.Rd_Data, bus.Rd_Tag} !== sb_q[0]) begin
               n_fail++;
               $display("FAIL pop_entry: got %0h expected %0h", {bus.Rd_PC, bus.Rd_Data, bus.Rd_Tag}, sb_q[0]);
            end
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset            = 1'b0;
      bus.Enable       = 1'b0;
      bus.Mode         = 1'b0;
      bus.TrigEn       = 1'b0;
      bus.TrigPC       = '0;
      bus.PC_In        = '0;
      bus.WriteData_In = '0;
      bus.RegWrite_In  = 1'b0;
      bus.Ch_In        = '0;
      bus.Rd_Ready     = 1'b0;
      sb_q.delete();
      step();
      Reset = 1'b1;
      step();
   endtask

   // One writeback cycle; the model keeps DEPTH entries and applies the full policy.
   task automatic wb(input logic [31:0] pc, input logic [31:0] data, input logic capture);
      bus.RegWrite_In  = 1'b1;
      bus.PC_In        = pc;
      bus.WriteData_In = data;
      if (capture) begin
         if (sb_q.size() < DEPTH) begin
            sb_q.push_back({pc, data, 4'd0});
         end else if (bus.Mode) begin
            void'(sb_q.pop_front());
            sb_q.push_back({pc, data, 4'd0});
         end
      end
      step();
      bus.RegWrite_In = 1'b0;
   endtask

   task automatic drain();
      bus.Rd_Ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (sb_q.size() == 0 && bus.Rd_Valid == 1'b0) break;
         step();
      end
      bus.Rd_Ready = 1'b0;
      chk("drain_left", 64'(sb_q.size()), 64'd0);
      chk("drain_count", 64'(bus.Count), 64'd0);
   endtask

   task automatic set_row(input int i, input logic rw, input logic [31:0] pc, input logic [31:0] wd,
                          input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                          input logic [31:0] c3, input logic st, input logic [31:0] d,
                          input logic [3:0] tag, input logic [15:0] drop);
      tbl[i].rw = rw;  tbl[i].pc = pc;  tbl[i].wd = wd;
      tbl[i].ch = {c3, c2, c1, c0};
      tbl[i].st = st;  tbl[i].exp_data = d;  tbl[i].exp_tag = tag;  tbl[i].exp_drop = drop;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      set_row(0, 1'b1, 32'h200, 32'hAAAA, 32'h0, 32'h0,  32'h0, 32'h0,  1'b1, 32'hAAAA, 4'd0, 16'd0);
      set_row(1, 1'b1, 32'h204, 32'hBBBB, 32'h0, 32'h0,  32'h7, 32'h0,  1'b1, 32'hBBBB, 4'd0, 16'd1);
      set_row(2, 1'b0, 32'h208, 32'h0,    32'h0, 32'h11, 32'h7, 32'h33, 1'b1, 32'h11,   4'd2, 16'd2);
      set_row(3, 1'b0, 32'h20C, 32'h0,    32'h0, 32'h11, 32'h7, 32'h33, 1'b0, 32'h0,    4'd0, 16'd2);
      set_row(4, 1'b0, 32'h210, 32'h0,    32'h5, 32'h11, 32'h7, 32'h33, 1'b1, 32'h5,    4'd1, 16'd2);
      set_row(5, 1'b0, 32'h214, 32'h0,    32'h5, 32'h11, 32'h7, 32'h34, 1'b1, 32'h34,   4'd4, 16'd2);
      set_row(6, 1'b1, 32'h218, 32'h0,    32'h5, 32'h11, 32'h7, 32'h34, 1'b1, 32'h0,    4'd0, 16'd2);
      set_row(7, 1'b0, 32'h21C, 32'h0,    32'h6, 32'h12, 32'h8, 32'h35, 1'b1, 32'h6,    4'd1, 16'd3);

      Reset            = 1'b0;
      bus.Enable       = 1'b0;
      bus.Mode         = 1'b0;
      bus.TrigEn       = 1'b0;
      bus.TrigPC       = '0;
      bus.PC_In        = '0;
      bus.WriteData_In = '0;
      bus.RegWrite_In  = 1'b0;
      bus.Ch_In        = '0;
      bus.Rd_Ready     = 1'b0;
      #1;
      chk("rst_valid", 64'(bus.Rd_Valid), 64'd0);
      chk("rst_count", 64'(bus.Count), 64'd0);
      chk("rst_full", 64'(bus.Full), 64'd0);
      chk("rst_ovf", 64'(bus.Overflow), 64'd0);
      chk("rst_drop", 64'(bus.Dropped), 64'd0);
      chk("rst_state", 64'(bus.State), 64'd0);
      chk("rst_head", {bus.Rd_PC, bus.Rd_Data[27:0], bus.Rd_Tag}, 64'd0);
      do_reset();

      // Single writeback, visible the cycle after it commits.
      bus.Enable = 1'b1;
      step();
      chk("go_capture", 64'(bus.State), 64'd2);
      wb(32'h40, 32'h1234, 1'b1);
      chk("wb_valid", 64'(bus.Rd_Valid), 64'd1);
      chk("wb_pc", 64'(bus.Rd_PC), 64'h40);
      chk("wb_data", 64'(bus.Rd_Data), 64'h1234);
      chk("wb_tag", 64'(bus.Rd_Tag), 64'd0);
      chk("wb_count", 64'(bus.Count), 64'd1);
      drain();

      // Event-selection table with the reader always ready.
      do_reset();
      bus.Enable   = 1'b1;
      bus.Rd_Ready = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
         bus.RegWrite_In  = tbl[i].rw;
         bus.PC_In        = tbl[i].pc;
         bus.WriteData_In = tbl[i].wd;
         bus.Ch_In        = tbl[i].ch;
         if (tbl[i].st) sb_q.push_back({tbl[i].pc, tbl[i].exp_data, tbl[i].exp_tag});
         step();
         chk($sformatf("row%0d_dropped", i), 64'(bus.Dropped), 64'(tbl[i].exp_drop));
      end
      bus.RegWrite_In = 1'b0;
      drain();

      // Stop-when-full, then a pop in STOPPED frees space without restarting.
      do_reset();
      bus.Enable = 1'b1;
      step();
      for (int i = 0; i < DEPTH + 3; i++) wb(32'h1000 + 32'(4 * i), 32'(i), 1'b1);
      chk("stop_full", 64'(bus.Full), 64'd1);
      chk("stop_state", 64'(bus.State), 64'd3);
      chk("stop_count", 64'(bus.Count), 64'(DEPTH));
      chk("stop_drop", 64'(bus.Dropped), 64'd3);
      chk("stop_head", 64'(bus.Rd_PC), 64'h1000);
      bus.Rd_Ready = 1'b1;
      step();
      bus.Rd_Ready = 1'b0;
      wb(32'h2000, 32'hDEAD, 1'b0);
      chk("stopped_count", 64'(bus.Count), 64'(DEPTH - 1));
      chk("stopped_drop", 64'(bus.Dropped), 64'd4);
      chk("stopped_state", 64'(bus.State), 64'd3);
      drain();

      // Wrap mode overwrites the oldest entries.
      do_reset();
      bus.Enable = 1'b1;
      bus.Mode   = 1'b1;
      step();
      for (int i = 0; i < DEPTH + 3; i++) wb(32'h3000 + 32'(4 * i), 32'h100 + 32'(i), 1'b1);
      chk("wrap_count", 64'(bus.Count), 64'(DEPTH));
      chk("wrap_ovf", 64'(bus.Overflow), 64'd1);
      chk("wrap_head_pc", 64'(bus.Rd_PC), 64'h300C);
      chk("wrap_head_data", 64'(bus.Rd_Data), 64'h103);
      chk("wrap_drop", 64'(bus.Dropped), 64'd0);
      drain();

      // PC-match trigger.
      do_reset();
      bus.Enable = 1'b1;
      bus.TrigEn = 1'b1;
      bus.TrigPC = 32'h100;
      step();
      chk("trig_armed", 64'(bus.State), 64'd1);
      wb(32'hF8, 32'h1, 1'b0);
      wb(32'hFC, 32'h2, 1'b0);
      chk("trig_wait", 64'(bus.Count), 64'd0);
      wb(32'h100, 32'h3, 1'b1);
      wb(32'h104, 32'h4, 1'b1);
      chk("trig_count", 64'(bus.Count), 64'd2);
      chk("trig_state", 64'(bus.State), 64'd2);
      chk("trig_head", 64'(bus.Rd_PC), 64'h100);
      chk("trig_drop", 64'(bus.Dropped), 64'd0);
      drain();

      // Disable keeps contents; reset between edges clears everything at once.
      do_reset();
      bus.Enable = 1'b1;
      step();
      for (int i = 0; i < 5; i++) wb(32'h500 + 32'(4 * i), 32'(i), 1'b1);
      chk("pre_count", 64'(bus.Count), 64'd5);
      bus.Enable = 1'b0;
      step();
      chk("dis_state", 64'(bus.State), 64'd0);
      chk("dis_count", 64'(bus.Count), 64'd5);
      chk("dis_valid", 64'(bus.Rd_Valid), 64'd1);
      Reset = 1'b0;
      #2;
      chk("arst_count", 64'(bus.Count), 64'd0);
      chk("arst_valid", 64'(bus.Rd_Valid), 64'd0);
      chk("arst_state", 64'(bus.State), 64'd0);
      chk("arst_head", 64'(bus.Rd_PC), 64'd0);
      sb_q.delete();
      step();
      Reset = 1'b1;
      step();
      chk("post_count", 64'(bus.Count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the PC, data and channel words.
REQ-002 SHALL have parameter NUM_CH, default 4: number of watched-register channels (1..15).
REQ-003 SHALL have parameter DEPTH, default 16: trace buffer entries, power of two, at least 2.
REQ-004 SHALL have port Clk  in  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port Enable  in  1  arms capture; low returns the block to IDLE.
REQ-007 SHALL have port Mode  in  1  0 = stop when full, 1 = wrap and overwrite oldest.
REQ-008 SHALL have ports TrigEn  in  1 and TrigPC  in  DATA_W  optional PC-match start trigger.
REQ-009 SHALL have ports PC_In  in  DATA_W, WriteData_In  in  DATA_W, RegWrite_In  in  1  processor writeback commit.
REQ-010 SHALL have port Ch_In  in  NUM_CH*DATA_W  watched registers; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have ports Rd_Valid  out  1 and Rd_Ready  in  1  readout handshake.
REQ-012 SHALL have ports Rd_PC  out  DATA_W, Rd_Data  out  DATA_W, Rd_Tag  out  4  head entry; Tag 0 = writeback, k+1 = channel k.
REQ-013 SHALL have ports Count  out  clog2(DEPTH)+1, Full  out  1, Overflow  out  1 (sticky), Dropped  out  16 (saturating).

Function
REQ-014 SHALL implement states IDLE, ARMED, CAPTURE and STOPPED.
REQ-015 SHALL move IDLE to ARMED when Enable=1 and TrigEn=1, and IDLE to CAPTURE when Enable=1 and TrigEn=0.
REQ-016 SHALL move ARMED to CAPTURE in the cycle PC_In==TrigPC; that cycle's event is captured.
REQ-017 SHALL move CAPTURE to STOPPED when Mode=0 and a push makes the buffer full.
REQ-018 SHALL return from any state to IDLE on the next edge when Enable=0; buffer contents are retained.
REQ-019 SHALL keep one shadow register per channel, loaded from Ch_In every cycle in every state.
REQ-020 SHALL detect at most one event per cycle, only in CAPTURE:
- RegWrite_In=1 gives an event of {PC_In, WriteData_In, tag 0};
- otherwise the lowest k with Ch_In[k] != shadow[k] gives {PC_In, Ch_In[k], tag k+1}.
REQ-021 SHALL increment Dropped by one in any CAPTURE or STOPPED cycle where at least one writeback or channel change is not stored; Dropped saturates at 16'hFFFF.
REQ-022 SHALL store a pushed entry so that it is visible on Rd_* with Rd_Valid=1 one cycle after its event cycle.
REQ-023 SHALL drive Rd_Valid = (Count != 0), with Rd_* showing the oldest entry; a pop occurs on a cycle with Rd_Valid and Rd_Ready both high.
REQ-024 SHALL, on simultaneous push and pop, perform both, leaving Count unchanged, including when full.
REQ-025 SHALL, with Mode=0 and full and no pop, discard the event and count it in Dropped.
REQ-026 SHALL, with Mode=1 and full and no pop, overwrite the oldest entry, advance the read pointer, keep Count=DEPTH and set Overflow.
REQ-027 SHALL allow reads in every state; pops in STOPPED free space but do not leave STOPPED.
REQ-028 SHALL wrap pointers modulo DEPTH; Full = (Count == DEPTH).

Reset
REQ-029 SHALL, while Reset=0, force the following, independent of Clk: state IDLE, pointers 0, Count 0, Rd_Valid 0, Full 0, Overflow 0, Dropped 0, shadows 0, Rd_PC/Rd_Data/Rd_Tag 0.
REQ-030 SHALL, when reset is asserted mid-capture, discard all buffered entries.

Verification
REQ-031 SHALL check: Enable=1, TrigEn=0, RegWrite pulse with PC=0x40, data=0x1234 -> next cycle Rd_Valid=1, Rd_PC=0x40, Rd_Data=0x1234, Tag=0, Count=1.
REQ-032 SHALL check: Ch_In[2] changes to 0x7 in the same cycle as a RegWrite -> writeback stored, Dropped=1; Ch_In[1] and Ch_In[3] changing in one cycle -> Tag=2 stored, Dropped=2.
REQ-033 SHALL check: Mode=0, DEPTH+3 writebacks with Rd_Ready=0 -> Full=1, state STOPPED, Count=DEPTH, Dropped=3, first entry unchanged.
REQ-034 SHALL check: Mode=1, DEPTH+3 writebacks -> Count=DEPTH, Overflow=1, head is the 4th event.
REQ-035 SHALL check: TrigEn=1, TrigPC=0x100, writebacks at PC 0xF8, 0xFC, 0x100, 0x104 -> only 0x100 and 0x104 are stored.
REQ-036 SHALL check: Reset pulsed low between edges with Count=5 -> Count=0, Rd_Valid=0 immediately, state IDLE.
